// File: rtl/refresh_scheduler_pkg.sv
// Shared types and constants for the DDR refresh scheduler.
package refresh_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CMD  = 2'd2,
        S_RFC  = 2'd3
    } ref_state_e;

    localparam int DDR3_MAX_POSTPONE = 8;

    // Width of a counter that must hold values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Refresh arbitration and command handshake between the scheduler (master),
// the transaction engine and the DFI command mux (slave side).
interface refresh_scheduler_if;
    logic tran_idle;
    logic ref_gnt;
    logic ref_cmd_ready;
    logic ref_req;
    logic ref_urgent;
    logic ref_cmd_valid;

    modport master (
        input  tran_idle,
        input  ref_gnt,
        input  ref_cmd_ready,
        output ref_req,
        output ref_urgent,
        output ref_cmd_valid
    );

    modport slave (
        output tran_idle,
        output ref_gnt,
        output ref_cmd_ready,
        input  ref_req,
        input  ref_urgent,
        input  ref_cmd_valid
    );
endinterface

// File: rtl/ref_interval_timer.sv
// tREFI interval timer: registered one-cycle tick every T_REFI cycles while enabled.
// A count of 0 means "idle"; the first tick lands T_REFI cycles after enable rises.
module ref_interval_timer #(
    parameter int T_REFI = 780
) (
    input  logic core_clk,
    input  logic core_arstn,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(T_REFI + 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FIRST = CW'(T_REFI - 1);
    localparam logic [CW-1:0] CNT_NEXT  = CW'(T_REFI);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Down-counter: arm on enable, tick and reload on reaching one.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= CNT_ZERO;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_ZERO) begin
            cnt_r  <= CNT_FIRST;
            tick_r <= 1'b0;
        end else if (cnt_r == CNT_ONE) begin
            cnt_r  <= CNT_NEXT;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r - CNT_ONE;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/refresh_scheduler_chk.sv
// Protocol checks on the refresh handshake: grant held while requested,
// REF command never retracted before acceptance.
module refresh_scheduler_chk (
    input logic core_clk,
    input logic core_arstn,
    input logic ref_req,
    input logic ref_gnt,
    input logic ref_cmd_valid,
    input logic ref_cmd_ready
);
    // Engine must not withdraw the grant while the scheduler still requests.
    gnt_held_a: assert property (@(posedge core_clk) disable iff (!core_arstn)
        (ref_req && ref_gnt) |=> (ref_gnt || !ref_req))
        else $error("ref_gnt dropped while ref_req high");

    // A presented REF stays presented until accepted.
    cmd_stable_a: assert property (@(posedge core_clk) disable iff (!core_arstn)
        (ref_cmd_valid && !ref_cmd_ready) |=> ref_cmd_valid)
        else $error("ref_cmd_valid retracted before acceptance");
endmodule

// File: rtl/refresh_scheduler.sv
// DDR auto-refresh scheduler: tREFI tick, owed-refresh tracking, cmd-path arbitration, tRFC spacing.
// Optional REF_STATS_EN adds ref_issued_cnt and ref_max_owed statistics outputs.
module refresh_scheduler
    import refresh_scheduler_pkg::*;
#(
    parameter int T_REFI       = 780,
    parameter int T_RFC        = 44,
    parameter int MAX_POSTPONE = DDR3_MAX_POSTPONE,
    parameter int URGENT_TH    = 6,
    localparam int OW          = count_width(MAX_POSTPONE)
) (
    input  logic                  core_clk,
    input  logic                  core_arstn,
    input  logic                  ref_en,
    refresh_scheduler_if.master   ref_bus,
    output logic                  ref_busy,
    output logic [OW-1:0]         ref_owed,
    output logic                  ref_overflow
`ifdef REF_STATS_EN
    ,
    output logic [15:0]           ref_issued_cnt,
    output logic [OW-1:0]         ref_max_owed
`endif
);
    localparam int RW = count_width(T_RFC);
    localparam logic [OW-1:0] OWED_ZERO = OW'(0);
    localparam logic [OW-1:0] OWED_ONE  = OW'(1);
    localparam logic [OW-1:0] OWED_MAX  = OW'(MAX_POSTPONE);
    localparam logic [OW-1:0] OWED_URG  = OW'(URGENT_TH);
    localparam logic [RW-1:0] RFC_ZERO  = RW'(0);
    localparam logic [RW-1:0] RFC_ONE   = RW'(1);
    // S_RFC lasts T_RFC-1 cycles so the next acceptance lands exactly T_RFC after the last.
    localparam logic [RW-1:0] RFC_LOAD  = RW'(T_RFC - 2);

    ref_state_e    state_r;
    logic          req_r;
    logic          valid_r;
    logic [OW-1:0] owed_r;
    logic          overflow_r;
    logic [RW-1:0] rfc_r;
    logic          tick_s;
    logic          accept_s;
    logic          urgent_s;

    ref_interval_timer #(.T_REFI(T_REFI)) u_timer (
        .core_clk   (core_clk),
        .core_arstn (core_arstn),
        .en         (ref_en),
        .tick       (tick_s)
    );

    assign accept_s = valid_r & ref_bus.ref_cmd_ready;
    assign urgent_s = (owed_r >= OWED_URG);

    // Owed-refresh bookkeeping and sticky overflow flag.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            owed_r     <= OWED_ZERO;
            overflow_r <= 1'b0;
        end else if (!ref_en) begin
            owed_r     <= OWED_ZERO;
        end else if (tick_s && !accept_s) begin
            if (owed_r == OWED_MAX) begin
                overflow_r <= 1'b1;
            end else begin
                owed_r <= owed_r + OWED_ONE;
            end
        end else if (accept_s && !tick_s && (owed_r != OWED_ZERO)) begin
            owed_r <= owed_r - OWED_ONE;
        end
    end

    // Arbitration / command FSM with registered ref_req and ref_cmd_valid.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_r <= S_IDLE;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
            rfc_r   <= RFC_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ref_en && (owed_r != OWED_ZERO) && (ref_bus.tran_idle || urgent_s)) begin
                        state_r <= S_REQ;
                        req_r   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ref_bus.ref_gnt) begin
                        state_r <= S_CMD;
                        valid_r <= 1'b1;
                    end else if (!ref_en) begin
                        state_r <= S_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                S_CMD: begin
                    if (accept_s) begin
                        state_r <= S_RFC;
                        valid_r <= 1'b0;
                        rfc_r   <= RFC_LOAD;
                    end
                end
                S_RFC: begin
                    if (rfc_r != RFC_ZERO) begin
                        rfc_r <= rfc_r - RFC_ONE;
                    end else if (ref_en && (owed_r != OWED_ZERO)) begin
                        state_r <= S_CMD;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= S_IDLE;
                        req_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    rfc_r   <= RFC_ZERO;
                end
            endcase
        end
    end

    assign ref_bus.ref_req       = req_r;
    assign ref_bus.ref_cmd_valid = valid_r;
    assign ref_bus.ref_urgent    = urgent_s;
    assign ref_busy              = (state_r != S_IDLE);
    assign ref_owed              = owed_r;
    assign ref_overflow          = overflow_r;

`ifdef REF_STATS_EN
    logic [15:0]   issued_r;
    logic [OW-1:0] max_owed_r;

    // Acceptance counter (wraps) and owed high-water mark.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            issued_r   <= 16'd0;
            max_owed_r <= OWED_ZERO;
        end else begin
            if (accept_s) begin
                issued_r <= issued_r + 16'd1;
            end
            if (owed_r > max_owed_r) begin
                max_owed_r <= owed_r;
            end
        end
    end

    assign ref_issued_cnt = issued_r;
    assign ref_max_owed   = max_owed_r;
`endif

    refresh_scheduler_chk u_chk (
        .core_clk      (core_clk),
        .core_arstn    (core_arstn),
        .ref_req       (req_r),
        .ref_gnt       (ref_bus.ref_gnt),
        .ref_cmd_valid (valid_r),
        .ref_cmd_ready (ref_bus.ref_cmd_ready)
    );
endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler (T_REFI=100, T_RFC=10, MAX_POSTPONE=8, URGENT_TH=6).
module tb_refresh_scheduler;
    logic       core_clk = 1'b0;
    logic       core_arstn = 1'b0;
    logic       ref_en = 1'b0;
    logic       ref_busy;
    logic [3:0] ref_owed;
    logic       ref_overflow;
`ifdef REF_STATS_EN
    logic [15:0] ref_issued_cnt;
    logic [3:0]  ref_max_owed;
`endif

    refresh_scheduler_if bus ();

    refresh_scheduler #(
        .T_REFI(100), .T_RFC(10), .MAX_POSTPONE(8), .URGENT_TH(6)
    ) dut (
        .core_clk     (core_clk),
        .core_arstn   (core_arstn),
        .ref_en       (ref_en),
        .ref_bus      (bus),
        .ref_busy     (ref_busy),
        .ref_owed     (ref_owed),
        .ref_overflow (ref_overflow)
`ifdef REF_STATS_EN
        ,
        .ref_issued_cnt (ref_issued_cnt),
        .ref_max_owed   (ref_max_owed)
`endif
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        int         at;     // cycle to check at; negative = reset and restart
        logic       idle;
        logic       ready;
        logic       allow;
        logic       req;
        logic       valid;
        logic       urg;
        logic       busy;
        logic [3:0] owed;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic gnt_allow = 1'b0;
    logic prev_req = 1'b0;

    function automatic void add(input int at, input logic idle, input logic ready, input logic allow,
                                input logic req, input logic valid, input logic urg, input logic busy,
                                input logic [3:0] owed);
        vec_t v;
        v = '{at, idle, ready, allow, req, valid, urg, busy, owed};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: responder grants one cycle after seeing ref_req.
    task automatic step();
        @(posedge core_clk);
        cyc++;
        #1;
        bus.ref_gnt = gnt_allow & prev_req;
        prev_req = bus.ref_req;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    task automatic start(input logic idle, input logic ready, input logic allow);
        core_arstn = 1'b0;
        ref_en = 1'b0;
        bus.tran_idle = idle;
        bus.ref_cmd_ready = ready;
        bus.ref_gnt = 1'b0;
        gnt_allow = allow;
        prev_req = 1'b0;
        repeat (2) @(posedge core_clk);
        #1 core_arstn = 1'b1;
        @(posedge core_clk);
        #1 ref_en = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic valid, input logic urg,
                            input logic busy, input logic [3:0] owed);
        chk({tag, ".req"},   {31'd0, bus.ref_req},       {31'd0, req});
        chk({tag, ".valid"}, {31'd0, bus.ref_cmd_valid}, {31'd0, valid});
        chk({tag, ".urg"},   {31'd0, bus.ref_urgent},    {31'd0, urg});
        chk({tag, ".busy"},  {31'd0, ref_busy},          {31'd0, busy});
        chk({tag, ".owed"},  {28'd0, ref_owed},          {28'd0, owed});
    endtask

    initial begin
        int req_seen;
        bus.tran_idle = 1'b0;
        bus.ref_cmd_ready = 1'b0;
        bus.ref_gnt = 1'b0;
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset.ovf", {31'd0, ref_overflow}, 32'd0);

        // Basic refresh: idle engine, responsive grant, ready high.
        add(-1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        add(102, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        add(103, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
        add(104, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
        add(105, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        add(113, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        add(114, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(150, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        // Busy engine: only urgent refresh, then a 6-REF burst 10 cycles apart.
        add(-1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(501, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        add(601, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd6);
        add(602, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd6);
        add(604, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
        add(605, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        add(613, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        add(614, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
        add(624, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
        add(634, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        add(644, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2);
        add(654, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1);
        add(655, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        add(664, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        add(701, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].at < 0) begin
                start(vecs[i].idle, vecs[i].ready, vecs[i].allow);
            end else begin
                go(vecs[i].at);
                bus.tran_idle = vecs[i].idle;
                bus.ref_cmd_ready = vecs[i].ready;
                gnt_allow = vecs[i].allow;
                chk_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].valid, vecs[i].urg,
                         vecs[i].busy, vecs[i].owed);
            end
        end

        // Grant withheld: owed saturates at 8, ninth tick sets sticky overflow.
        start(1'b1, 1'b1, 1'b0);
        go(801);
        chk_outs("sat", 1'b1, 1'b0, 1'b1, 1'b1, 4'd8);
        chk("sat.ovf", {31'd0, ref_overflow}, 32'd0);
        go(901);
        chk("ovf.owed", {28'd0, ref_owed}, 32'd8);
        chk("ovf.set", {31'd0, ref_overflow}, 32'd1);
        go(950);
        ref_en = 1'b0;
        go(952);
        chk_outs("ovf.dis", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("ovf.sticky", {31'd0, ref_overflow}, 32'd1);
        core_arstn = 1'b0;
        #1;
        chk("ovf.rst", {31'd0, ref_overflow}, 32'd0);

        // Tick coincident with acceptance at owed=3.
        start(1'b1, 1'b0, 1'b0);
        go(301);
        chk_outs("coin.pre", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        go(310);
        gnt_allow = 1'b1;
        go(399);
        chk("coin.hold", {31'd0, bus.ref_cmd_valid}, 32'd1);
        go(400);
        bus.ref_cmd_ready = 1'b1;
        go(401);
        chk("coin.owed", {28'd0, ref_owed}, 32'd3);
        go(411);
        chk("coin.owed2", {28'd0, ref_owed}, 32'd2);
        go(431);
        chk("coin.drain", {28'd0, ref_owed}, 32'd0);
        go(440);
        chk_outs("coin.end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        // ref_en falls while a REF waits for ready: command held, then released.
        start(1'b1, 1'b0, 1'b1);
        go(110);
        chk("dis.valid", {31'd0, bus.ref_cmd_valid}, 32'd1);
        ref_en = 1'b0;
        go(115);
        chk_outs("dis.held", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        go(120);
        bus.ref_cmd_ready = 1'b1;
        go(121);
        chk_outs("dis.acc", 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        go(130);
        chk_outs("dis.idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        req_seen = 0;
        while (cyc < 300) begin
            step();
            if (bus.ref_req) req_seen++;
        end
        chk("dis.noreq", req_seen, 32'd0);

        // Asynchronous reset in the middle of tRFC.
        start(1'b1, 1'b1, 1'b1);
        go(108);
        chk("rfc.busy", {31'd0, ref_busy}, 32'd1);
`ifdef REF_STATS_EN
        chk("stats.issued", {16'd0, ref_issued_cnt}, 32'd1);
        chk("stats.max", {28'd0, ref_max_owed}, 32'd1);
`endif
        #2 core_arstn = 1'b0;
        #1;
        chk_outs("arst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("arst.ovf", {31'd0, ref_overflow}, 32'd0);
`ifdef REF_STATS_EN
        chk("arst.issued", {16'd0, ref_issued_cnt}, 32'd0);
`endif
        @(posedge core_clk);
        #1 core_arstn = 1'b1;
        bus.ref_gnt = 1'b0;
        prev_req = 1'b0;
        cyc = 0;
        go(100);
        chk("arst.t100", {28'd0, ref_owed}, 32'd0);
        go(101);
        chk("arst.t101", {28'd0, ref_owed}, 32'd1);
        go(102);
        chk("arst.req", {31'd0, bus.ref_req}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
